// File: rtl/risc_core_mc.sv
// risc_core_mc: parametrised multi-cycle microcontroller core.
// Instructions arrive over a valid/ready handshake. Each one is latched in IDLE,
// executed in EXEC, and DIV/MOD then iterate a restoring divider in the DIV state.
// Ports:
//   clk, reset (async, active-high)
//   instr/instr_valid/instr_ready : instruction handshake {op, rd, rs1, imm}
//   result/result_valid           : last produced value and its one-cycle strobe
//   zero/carry/neg_flag           : flags of the last flag-updating op
//   div_busy, div_by_zero         : divider iterating, sticky divide-by-zero
//   dbg_addr/dbg_data             : combinational register-file peek
module risc_core_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 4,
    parameter int unsigned IMM_W  = 8,
    localparam int unsigned RAW     = $clog2(NREGS),
    localparam int unsigned INSTR_W = 4 + 2*RAW + IMM_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               neg_flag,
    output logic               div_busy,
    output logic               div_by_zero,
    input  logic [RAW-1:0]     dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);
    localparam int unsigned SHW = $clog2(DATA_W);
    localparam int unsigned CW  = $clog2(DATA_W + 1);
    localparam int unsigned PW  = 2 * DATA_W;

    localparam logic [3:0] OP_ADD  = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7, OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9, OP_MUL = 4'hA, OP_DIV = 4'hB, OP_MOD = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD, OP_OUT = 4'hE;

    typedef enum logic [1:0] {IDLE, EXEC, DIV} state_t;

    state_t              state, state_d;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NREGS];

    // Decoded fields of the latched instruction
    logic [3:0]          op;
    logic [RAW-1:0]      rd, rs1, rs2;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   a, b, imm_ext;
    logic [SHW-1:0]      shamt;
    logic [PW-1:0]       prod;

    assign op      = ir[INSTR_W-1 -: 4];
    assign rd      = ir[IMM_W+RAW +: RAW];
    assign rs1     = ir[IMM_W +: RAW];
    assign imm     = ir[IMM_W-1:0];
    assign rs2     = imm[RAW-1:0];
    assign a       = regs[rs1];
    assign b       = regs[rs2];
    assign imm_ext = DATA_W'(imm);
    assign shamt   = b[SHW-1:0];
    assign prod    = PW'(a) * PW'(b);

    assign instr_ready = (state == IDLE);
    assign div_busy    = (state == DIV);
    assign dbg_data    = regs[dbg_addr];

    // Restoring divider: dividend shifts out of quo into rem, quotient bits shift in
    logic [DATA_W-1:0]   div_rem, div_quo, div_dvs;
    logic [CW-1:0]       div_cnt;
    logic [DATA_W:0]     rem_sh, rem_sub;
    logic                q_bit, div_last;
    logic [DATA_W-1:0]   rem_nx, quo_nx;

    assign rem_sh   = {div_rem, div_quo[DATA_W-1]};
    assign rem_sub  = rem_sh - {1'b0, div_dvs};
    assign q_bit    = ~rem_sub[DATA_W];
    assign rem_nx   = q_bit ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quo_nx   = {div_quo[DATA_W-2:0], q_bit};
    assign div_last = (div_cnt == CW'(DATA_W - 1));

    // Control and ALU
    logic                ir_load, wr_en, flag_en, res_en, div_load, dbz_set, alu_c;
    logic [DATA_W-1:0]   alu_res;

    always_comb begin
        state_d  = state;
        ir_load  = 1'b0;
        wr_en    = 1'b0;
        flag_en  = 1'b0;
        res_en   = 1'b0;
        div_load = 1'b0;
        dbz_set  = 1'b0;
        alu_c    = 1'b0;
        alu_res  = '0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    ir_load = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                {wr_en, flag_en, res_en} = 3'b111;
                case (op)
                    OP_ADD:  {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
                    OP_SUB:  {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
                    OP_AND:  alu_res = a & b;
                    OP_OR:   alu_res = a | b;
                    OP_XOR:  alu_res = a ^ b;
                    OP_SHL:  {alu_c, alu_res} = {1'b0, a} << shamt;
                    OP_SHR:  {alu_res, alu_c} = {a, 1'b0} >> shamt;
                    OP_ADDI: {alu_c, alu_res} = {1'b0, a} + {1'b0, imm_ext};
                    OP_LDI: begin
                        alu_res = imm_ext;
                        flag_en = 1'b0;
                    end
                    OP_MUL: begin
                        alu_res = prod[DATA_W-1:0];
                        alu_c   = |prod[PW-1:DATA_W];
                    end
                    OP_DIV, OP_MOD: begin
                        if (b == '0) begin
                            alu_res = (op == OP_DIV) ? '1 : a;
                            dbz_set = 1'b1;
                        end else begin
                            {wr_en, flag_en, res_en} = 3'b000;
                            div_load = 1'b1;
                            state_d  = DIV;
                        end
                    end
                    OP_CMP: begin
                        {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
                        wr_en = 1'b0;
                    end
                    OP_OUT: begin
                        alu_res = a;
                        {wr_en, flag_en} = 2'b00;
                    end
                    default: {wr_en, flag_en, res_en} = 3'b000;
                endcase
            end
            DIV: begin
                if (div_last) begin
                    state_d = IDLE;
                    alu_res = (op == OP_DIV) ? quo_nx : rem_nx;
                    {wr_en, flag_en, res_en} = 3'b111;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Instruction latch, register file, result and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            zero_flag    <= 1'b0;
            carry_flag   <= 1'b0;
            neg_flag     <= 1'b0;
            div_by_zero  <= 1'b0;
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else begin
            result_valid <= res_en;
            if (ir_load) ir <= instr;
            if (wr_en)   regs[rd] <= alu_res;
            if (res_en)  result <= alu_res;
            if (flag_en) begin
                zero_flag  <= (alu_res == '0);
                carry_flag <= alu_c;
                neg_flag   <= alu_res[DATA_W-1];
            end
            if (dbz_set) div_by_zero <= 1'b1;
        end
    end

    // Divider datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_rem <= '0;
            div_quo <= '0;
            div_dvs <= '0;
            div_cnt <= '0;
        end else if (div_load) begin
            div_rem <= '0;
            div_quo <= a;
            div_dvs <= b;
            div_cnt <= '0;
        end else if (state == DIV) begin
            div_rem <= rem_nx;
            div_quo <= quo_nx;
            div_cnt <= div_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_risc_core_mc.sv
// Testbench for risc_core_mc: directed scenarios plus randomized instructions
// checked against an arithmetic reference model; a second 32-bit/8-register
// instance checks the wide divider latency.
`timescale 1ns/100ps
module tb_risc_core_mc;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam longint MASK = (64'd1 << DW) - 1;

    logic        clk, reset;
    logic [15:0] instr;
    logic        instr_valid, instr_ready;
    logic [15:0] result;
    logic        result_valid, zero_flag, carry_flag, neg_flag, div_busy, div_by_zero;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;

    logic [17:0] i32;
    logic        v32, rdy32, rv32, z32, c32, n32, busy32, dbz32;
    logic [31:0] res32, dbgd32;
    logic [2:0]  dbga32;

    int tests, fails;

    risc_core_mc u_dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .result(result), .result_valid(result_valid),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag),
        .div_busy(div_busy), .div_by_zero(div_by_zero),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    risc_core_mc #(.DATA_W(32), .NREGS(8), .IMM_W(8)) u_dut32 (
        .clk(clk), .reset(reset), .instr(i32), .instr_valid(v32),
        .instr_ready(rdy32), .result(res32), .result_valid(rv32),
        .zero_flag(z32), .carry_flag(c32), .neg_flag(n32),
        .div_busy(busy32), .div_by_zero(dbz32),
        .dbg_addr(dbga32), .dbg_data(dbgd32)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model state
    longint m_reg [NR];
    bit     m_z, m_c, m_n, m_dbz;
    longint m_res;

    // Observations from the last run, expectations from the model
    int o_lat, o_rlow, o_busy;
    bit o_rv, o_early, o_to;
    bit e_rv, e_div;
    int e_lat;

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int imm);
        return {4'(op), 2'(rd), 2'(rs1), 8'(imm)};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NR; k++) m_reg[k] = 0;
        {m_z, m_c, m_n, m_dbz} = 4'b0;
        m_res = 0;
    endtask

    // Architectural effect of one instruction, from the opcode table
    task automatic model_step(input logic [15:0] ins, output bit rv, output int lat, output bit dv);
        int op, rd, rs1, rs2, imm, s;
        longint a, b, r, p;
        bit c, w, f;
        op = int'(ins[15:12]); rd = int'(ins[11:10]); rs1 = int'(ins[9:8]);
        imm = int'(ins[7:0]); rs2 = int'(ins[1:0]);
        a = m_reg[rs1]; b = m_reg[rs2]; s = int'(b % DW);
        r = 0; c = 0; w = 1; f = 1; rv = 1; lat = 2; dv = 0;
        case (op)
            1:  begin r = a + b; c = (r > MASK); end
            2:  begin r = a - b; c = (a < b); end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  begin r = a << s; c = (s != 0) ? ((a >> (DW - s)) & 1) != 0 : 0; end
            7:  begin r = a >> s; c = (s != 0) ? ((a >> (s - 1)) & 1) != 0 : 0; end
            8:  begin r = a + imm; c = (r > MASK); end
            9:  begin r = imm; f = 0; end
            10: begin p = a * b; r = p; c = (p >> DW) != 0; end
            11, 12: begin
                if (b == 0) begin
                    r = (op == 11) ? MASK : a;
                    m_dbz = 1;
                end else begin
                    r = (op == 11) ? a / b : a % b;
                    lat = DW + 2;
                    dv = 1;
                end
            end
            13: begin r = a - b; c = (a < b); w = 0; end
            14: begin r = a; w = 0; f = 0; end
            default: begin rv = 0; w = 0; f = 0; end
        endcase
        r = r & MASK;
        if (w) m_reg[rd] = r;
        if (f) begin m_z = (r == 0); m_c = c; m_n = ((r >> (DW - 1)) & 1) != 0; end
        if (rv) m_res = r;
    endtask

    // Issue one instruction and observe it to completion; starts and ends 1ns after an edge
    task automatic run(input logic [15:0] ins);
        int n;
        n = 0;
        while (!instr_ready && n < 100) begin @(posedge clk); #1; n++; end
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        o_lat = 1; o_rlow = 0; o_busy = 0; o_early = 0;
        while (!instr_ready && o_lat < 200) begin
            o_rlow++;
            if (div_busy) o_busy++;
            if (result_valid) o_early = 1;
            @(posedge clk); #1;
            o_lat++;
        end
        o_to = !instr_ready;
        o_rv = result_valid;
    endtask

    task automatic exec(input logic [15:0] ins);
        model_step(ins, e_rv, e_lat, e_div);
        run(ins);
    endtask

    task automatic do_reset();
        instr_valid = 1'b0; v32 = 1'b0;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (instr_ready !== 1'b1 || div_busy !== 1'b0 || result_valid !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: ready/busy/rv=%b%b%b want 100", instr_ready, div_busy, result_valid);
        end
        tests++;
        if ({result, zero_flag, carry_flag, neg_flag, div_by_zero} !== 20'h0) begin
            fails++; $display("FAIL reset_out: result=%h flags=%b%b%b dbz=%b want all 0",
                              result, zero_flag, carry_flag, neg_flag, div_by_zero);
        end
        for (int k = 0; k < NR; k++) begin
            dbg_addr = 2'(k); #1;
            tests++;
            if (dbg_data !== 16'h0) begin fails++; $display("FAIL reset_reg%0d: got %h want 0000", k, dbg_data); end
        end
    endtask

    task automatic test_basic();
        exec(mk(9, 0, 0, 8'hFF));
        exec(mk(9, 1, 0, 8'h01));
        exec(mk(1, 2, 0, 1));
        tests++;
        if (o_lat !== 2 || o_rv !== 1'b1) begin fails++; $display("FAIL basic_add_lat: lat=%0d rv=%b want 2 1", o_lat, o_rv); end
        tests++;
        if (result !== 16'h0100 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
            fails++; $display("FAIL basic_add: result=%h z=%b c=%b want 0100 0 0", result, zero_flag, carry_flag);
        end
        exec(mk(2, 3, 1, 0));
        tests++;
        if (result !== 16'hFF02 || carry_flag !== 1'b1 || neg_flag !== 1'b1) begin
            fails++; $display("FAIL basic_sub: result=%h c=%b n=%b want ff02 1 1", result, carry_flag, neg_flag);
        end
        dbg_addr = 2'd3; #1;
        tests++;
        if (dbg_data !== 16'hFF02) begin fails++; $display("FAIL basic_sub_wb: r3=%h want ff02", dbg_data); end
    endtask

    task automatic test_overflow();
        exec(mk(9, 0, 0, 8'hFF));
        exec(mk(9, 1, 0, 8'd8));
        exec(mk(6, 0, 0, 1));
        tests++;
        if (result !== 16'hFF00 || carry_flag !== 1'b0) begin
            fails++; $display("FAIL ovf_shl: result=%h c=%b want ff00 0", result, carry_flag);
        end
        exec(mk(1, 0, 0, 0));
        tests++;
        if (result !== 16'hFE00 || carry_flag !== 1'b1) begin
            fails++; $display("FAIL ovf_add: result=%h c=%b want fe00 1", result, carry_flag);
        end
        exec(mk(13, 0, 0, 0));
        dbg_addr = 2'd0; #1;
        tests++;
        if (zero_flag !== 1'b1 || result !== 16'h0000 || dbg_data !== 16'hFE00) begin
            fails++; $display("FAIL ovf_cmp: z=%b result=%h r0=%h want 1 0000 fe00", zero_flag, result, dbg_data);
        end
    endtask

    task automatic test_divmod();
        exec(mk(9, 0, 0, 100));
        exec(mk(9, 1, 0, 7));
        exec(mk(11, 2, 0, 1));
        tests++;
        if (result !== 16'd14 || o_rv !== 1'b1) begin fails++; $display("FAIL div_q: result=%0d rv=%b want 14 1", result, o_rv); end
        tests++;
        if (o_lat !== 18 || o_rlow !== 17 || o_busy !== 16) begin
            fails++; $display("FAIL div_timing: lat=%0d ready_low=%0d busy=%0d want 18 17 16", o_lat, o_rlow, o_busy);
        end
        exec(mk(12, 3, 0, 1));
        dbg_addr = 2'd3; #1;
        tests++;
        if (result !== 16'd2 || dbg_data !== 16'd2 || carry_flag !== 1'b0) begin
            fails++; $display("FAIL mod_r: result=%0d r3=%0d c=%b want 2 2 0", result, dbg_data, carry_flag);
        end
    endtask

    task automatic test_div_zero();
        exec(mk(9, 1, 0, 0));
        exec(mk(11, 2, 0, 1));
        tests++;
        if (result !== 16'hFFFF || o_lat !== 2 || div_by_zero !== 1'b1 || carry_flag !== 1'b0) begin
            fails++; $display("FAIL dbz_div: result=%h lat=%0d dbz=%b c=%b want ffff 2 1 0",
                              result, o_lat, div_by_zero, carry_flag);
        end
        exec(mk(11, 3, 0, 2));
        tests++;
        if (div_by_zero !== 1'b1 || result !== 16'h0000 || o_lat !== 18) begin
            fails++; $display("FAIL dbz_sticky: dbz=%b result=%h lat=%0d want 1 0000 18", div_by_zero, result, o_lat);
        end
        exec(mk(12, 3, 0, 1));
        tests++;
        if (result !== 16'd100 || o_lat !== 2) begin fails++; $display("FAIL dbz_mod: result=%0d lat=%0d want 100 2", result, o_lat); end
    endtask

    task automatic test_reset_mid_div();
        int pulses;
        exec(mk(9, 0, 0, 100));
        exec(mk(9, 1, 0, 7));
        instr = mk(11, 2, 0, 1); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
        #1;
        tests++;
        if (div_busy !== 1'b0 || instr_ready !== 1'b1 || result_valid !== 1'b0 || div_by_zero !== 1'b0) begin
            fails++; $display("FAIL rst_div_ctrl: busy=%b ready=%b rv=%b dbz=%b want 0 1 0 0",
                              div_busy, instr_ready, result_valid, div_by_zero);
        end
        @(posedge clk); #1 reset = 1'b0;
        pulses = 0;
        repeat (25) begin @(posedge clk); #1; if (result_valid) pulses++; end
        tests++;
        if (pulses !== 0) begin fails++; $display("FAIL rst_div_nowb: result_valid pulses=%0d want 0", pulses); end
        for (int k = 0; k < NR; k++) begin
            dbg_addr = 2'(k); #1;
            tests++;
            if (dbg_data !== 16'h0) begin fails++; $display("FAIL rst_div_reg%0d: got %h want 0000", k, dbg_data); end
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int op;
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 9 : int'($urandom_range(0, 15));
            ins = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            exec(ins);
            tests++;
            if (o_to || o_lat !== e_lat) begin
                fails++; $display("FAIL rand_lat[%0d] op=%0h: got %0d want %0d", n, op, o_lat, e_lat);
            end
            tests++;
            if (o_rv !== e_rv || o_early) begin
                fails++; $display("FAIL rand_rv[%0d] op=%0h: rv=%b early=%b want %b 0", n, op, o_rv, o_early, e_rv);
            end
            if (e_rv) begin
                tests++;
                if (result !== 16'(m_res)) begin
                    fails++; $display("FAIL rand_res[%0d] op=%0h: got %h want %h", n, op, result, 16'(m_res));
                end
            end
            tests++;
            if ({zero_flag, carry_flag, neg_flag, div_by_zero} !== {m_z, m_c, m_n, m_dbz}) begin
                fails++; $display("FAIL rand_flags[%0d] op=%0h: zcn,dbz=%b%b%b,%b want %b%b%b,%b", n, op,
                                  zero_flag, carry_flag, neg_flag, div_by_zero, m_z, m_c, m_n, m_dbz);
            end
            tests++;
            if (o_rlow !== e_lat - 1 || o_busy !== (e_div ? DW : 0)) begin
                fails++; $display("FAIL rand_stall[%0d] op=%0h: ready_low=%0d busy=%0d want %0d %0d", n, op,
                                  o_rlow, o_busy, e_lat - 1, e_div ? DW : 0);
            end
            for (int k = 0; k < NR; k++) begin
                dbg_addr = 2'(k); #1;
                tests++;
                if (dbg_data !== 16'(m_reg[k])) begin
                    fails++; $display("FAIL rand_reg[%0d] r%0d: got %h want %h", n, k, dbg_data, 16'(m_reg[k]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [15:0] q [N];
        longint exp_q [$];
        int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13, 14};
        bit rv, dv, acc;
        int lat, k, cyc;
        for (int j = 0; j < N; j++) begin
            q[j] = mk((j == 5) ? 11 : ops[$urandom_range(0, 12)], int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            model_step(q[j], rv, lat, dv);
            if (rv) exp_q.push_back(m_res);
        end
        k = 0; instr = q[0]; instr_valid = 1'b1;
        for (cyc = 0; cyc < 600; cyc++) begin
            acc = instr_valid && instr_ready;
            @(posedge clk); #1;
            if (result_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL b2b_extra: unexpected result %h", result);
                end else if (result !== 16'(exp_q[0])) begin
                    fails++; $display("FAIL b2b_res: got %h want %h", result, 16'(exp_q[0]));
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (acc) begin
                k++;
                if (k == N) instr_valid = 1'b0;
                else        instr = q[k];
            end
            if (k == N && instr_ready && exp_q.size() == 0) break;
        end
        instr_valid = 1'b0;
        tests++;
        if (k !== N || exp_q.size() !== 0) begin
            fails++; $display("FAIL b2b_count: accepted=%0d pending=%0d want %0d 0", k, exp_q.size(), N);
        end
        for (int r = 0; r < NR; r++) begin
            dbg_addr = 2'(r); #1;
            tests++;
            if (dbg_data !== 16'(m_reg[r])) begin
                fails++; $display("FAIL b2b_reg r%0d: got %h want %h", r, dbg_data, 16'(m_reg[r]));
            end
        end
    endtask

    task automatic run32(input logic [17:0] ins, output int lat);
        int n;
        n = 0;
        while (!rdy32 && n < 100) begin @(posedge clk); #1; n++; end
        i32 = ins; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 1;
        while (!rdy32 && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_div32();
        int lat;
        run32({4'h9, 3'd5, 3'd0, 8'd200}, lat);
        run32({4'h9, 3'd6, 3'd0, 8'd7}, lat);
        run32({4'hB, 3'd7, 3'd5, 8'd6}, lat);
        dbga32 = 3'd7; #1;
        tests++;
        if (lat !== 34 || rv32 !== 1'b1 || res32 !== 32'd28 || dbgd32 !== 32'd28) begin
            fails++; $display("FAIL div32: lat=%0d rv=%b result=%0d r7=%0d want 34 1 28 28", lat, rv32, res32, dbgd32);
        end
        run32({4'hC, 3'd4, 3'd5, 8'd6}, lat);
        tests++;
        if (lat !== 34 || res32 !== 32'd4) begin fails++; $display("FAIL mod32: lat=%0d result=%0d want 34 4", lat, res32); end
        run32({4'h9, 3'd1, 3'd0, 8'hFF}, lat);
        run32({4'h9, 3'd2, 3'd0, 8'd24}, lat);
        run32({4'h6, 3'd3, 3'd1, 8'd2}, lat);
        tests++;
        if (lat !== 2 || res32 !== 32'hFF00_0000 || n32 !== 1'b1 || c32 !== 1'b0) begin
            fails++; $display("FAIL shl32: lat=%0d result=%h n=%b c=%b want 2 ff000000 1 0", lat, res32, n32, c32);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; instr = '0; instr_valid = 1'b0; dbg_addr = '0;
        i32 = '0; v32 = 1'b0; dbga32 = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_divmod();
        test_div_zero();
        test_reset_mid_div();
        test_random();
        test_back_to_back();
        test_div32();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
